// File: rtl/fake_68k.sv
// fake_68k: bus-functional MC68000 bus cycle generator (S0-S7, WAIT, BERR) driven by mock inputs.
// Optional macro FAKE68K_WAIT_TIMEOUT_EN: a 32-clock WAIT with no acknowledge becomes a bus error.

module fake_68k (
    input  logic        cpuclk,
    input  logic        cpurst,
    input  logic [2:0]  cycle_type,
    input  logic [23:0] mock_addr,
    input  logic [15:0] mock_data_to_write,
    input  logic [2:0]  mock_fc,
    output logic [15:0] data_read,
    output logic [4:0]  mock_state,
    input  logic        dtack_n,
    input  logic        berr_n,
    output logic [2:0]  fc,
    output logic        w_n,
    output logic [23:0] logaddr,
    inout  wire  [15:0] d,
    output logic        as_n,
    output logic        uds_n,
    output logic        lds_n
);

    typedef enum logic [4:0] {
        ST_IDLE = 5'd0,
        ST_S0   = 5'd1,
        ST_S1   = 5'd2,
        ST_S2   = 5'd3,
        ST_S3   = 5'd4,
        ST_S4   = 5'd5,
        ST_S5   = 5'd6,
        ST_S6   = 5'd7,
        ST_S7   = 5'd8,
        ST_WAIT = 5'd9,
        ST_BERR = 5'd10
    } state_t;

    state_t      state_r, state_s;
    logic [23:0] addr_r, addr_s;
    logic [15:0] wdata_r, wdata_s;
    logic [2:0]  fc_r, fc_s;
    logic        is_write_r, is_write_s;
    logic        sel_upper_r, sel_upper_s;
    logic        sel_lower_r, sel_lower_s;
    logic [15:0] data_read_r, data_read_s;
    logic        as_n_r, as_n_s;
    logic        uds_n_r, uds_n_s;
    logic        lds_n_r, lds_n_s;
    logic        w_n_r, w_n_s;
    logic        d_oe_r, d_oe_s;
    logic        addr_oe_r, addr_oe_s;
    logic        fc_oe_r, fc_oe_s;
    logic        start_s, dec_write_s, dec_upper_s, dec_lower_s;
`ifdef FAKE68K_WAIT_TIMEOUT_EN
    logic [4:0]  wait_cnt_r, wait_cnt_s;
`endif

    // Decode the requested cycle type into direction and byte lanes.
    always_comb begin
        start_s     = 1'b0;
        dec_write_s = 1'b0;
        dec_upper_s = 1'b0;
        dec_lower_s = 1'b0;
        case (cycle_type)
            3'd1: begin start_s = 1'b1; dec_upper_s = 1'b1; dec_lower_s = 1'b1; end
            3'd2: begin start_s = 1'b1; dec_write_s = 1'b1; dec_upper_s = 1'b1; dec_lower_s = 1'b1; end
            3'd3: begin start_s = 1'b1; dec_upper_s = 1'b1; end
            3'd4: begin start_s = 1'b1; dec_lower_s = 1'b1; end
            3'd5: begin start_s = 1'b1; dec_write_s = 1'b1; dec_upper_s = 1'b1; end
            3'd6: begin start_s = 1'b1; dec_write_s = 1'b1; dec_lower_s = 1'b1; end
            default: start_s = 1'b0;
        endcase
    end

`ifdef FAKE68K_WAIT_TIMEOUT_EN
    // Count consecutive WAIT clocks; cleared whenever the bus is not waiting.
    always_comb begin
        if (state_r == ST_WAIT) begin
            wait_cnt_s = wait_cnt_r + 5'd1;
        end else begin
            wait_cnt_s = 5'd0;
        end
    end
`endif

    // Next-state logic; mock inputs are captured only on the IDLE->S0 transition.
    always_comb begin
        state_s     = state_r;
        addr_s      = addr_r;
        wdata_s     = wdata_r;
        fc_s        = fc_r;
        is_write_s  = is_write_r;
        sel_upper_s = sel_upper_r;
        sel_lower_s = sel_lower_r;
        data_read_s = data_read_r;
        case (state_r)
            ST_IDLE: begin
                if (start_s) begin
                    state_s     = ST_S0;
                    addr_s      = mock_addr & 24'hFFFFFE;
                    wdata_s     = mock_data_to_write;
                    fc_s        = mock_fc;
                    is_write_s  = dec_write_s;
                    sel_upper_s = dec_upper_s;
                    sel_lower_s = dec_lower_s;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_S0: state_s = ST_S1;
            ST_S1: state_s = ST_S2;
            ST_S2: state_s = ST_S3;
            ST_S3: state_s = ST_S4;
            ST_S4, ST_WAIT: begin
                // Bus error takes priority over a simultaneous acknowledge.
                if (!berr_n) begin
                    state_s = ST_BERR;
                end else if (!dtack_n) begin
                    state_s = ST_S5;
`ifdef FAKE68K_WAIT_TIMEOUT_EN
                end else if ((state_r == ST_WAIT) && (wait_cnt_r == 5'd31)) begin
                    state_s = ST_BERR;
`endif
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_S5: state_s = ST_S6;
            ST_S6: begin
                state_s = ST_S7;
                if (!is_write_r) begin
                    data_read_s = d;
                end else begin
                    data_read_s = data_read_r;
                end
            end
            ST_S7:   state_s = ST_IDLE;
            ST_BERR: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // Bus pin levels for the state being entered, so they register alongside it.
    always_comb begin
        as_n_s    = 1'b1;
        uds_n_s   = 1'b1;
        lds_n_s   = 1'b1;
        w_n_s     = 1'b1;
        d_oe_s    = 1'b0;
        addr_oe_s = 1'b0;
        fc_oe_s   = 1'b0;
        case (state_s)
            ST_S0: fc_oe_s = 1'b1;
            ST_S1: begin
                fc_oe_s   = 1'b1;
                addr_oe_s = 1'b1;
            end
            ST_S2, ST_S3: begin
                fc_oe_s   = 1'b1;
                addr_oe_s = 1'b1;
                as_n_s    = 1'b0;
                w_n_s     = ~is_write_s;
                uds_n_s   = is_write_s | ~sel_upper_s;
                lds_n_s   = is_write_s | ~sel_lower_s;
                d_oe_s    = is_write_s & (state_s == ST_S3);
            end
            ST_S4, ST_WAIT, ST_S5, ST_S6: begin
                fc_oe_s   = 1'b1;
                addr_oe_s = 1'b1;
                as_n_s    = 1'b0;
                w_n_s     = ~is_write_s;
                uds_n_s   = ~sel_upper_s;
                lds_n_s   = ~sel_lower_s;
                d_oe_s    = is_write_s;
            end
            ST_S7: begin
                fc_oe_s   = 1'b1;
                addr_oe_s = 1'b1;
                w_n_s     = ~is_write_s;
            end
            ST_BERR: begin
                fc_oe_s   = 1'b1;
                addr_oe_s = 1'b1;
            end
            default: fc_oe_s = 1'b0;
        endcase
    end

    // State, latched cycle parameters and registered bus pins.
    always_ff @(posedge cpuclk) begin
        if (cpurst) begin
            state_r     <= ST_IDLE;
            addr_r      <= 24'h000000;
            wdata_r     <= 16'h0000;
            fc_r        <= 3'd0;
            is_write_r  <= 1'b0;
            sel_upper_r <= 1'b0;
            sel_lower_r <= 1'b0;
            data_read_r <= 16'h0000;
            as_n_r      <= 1'b1;
            uds_n_r     <= 1'b1;
            lds_n_r     <= 1'b1;
            w_n_r       <= 1'b1;
            d_oe_r      <= 1'b0;
            addr_oe_r   <= 1'b0;
            fc_oe_r     <= 1'b0;
`ifdef FAKE68K_WAIT_TIMEOUT_EN
            wait_cnt_r  <= 5'd0;
`endif
        end else begin
            state_r     <= state_s;
            addr_r      <= addr_s;
            wdata_r     <= wdata_s;
            fc_r        <= fc_s;
            is_write_r  <= is_write_s;
            sel_upper_r <= sel_upper_s;
            sel_lower_r <= sel_lower_s;
            data_read_r <= data_read_s;
            as_n_r      <= as_n_s;
            uds_n_r     <= uds_n_s;
            lds_n_r     <= lds_n_s;
            w_n_r       <= w_n_s;
            d_oe_r      <= d_oe_s;
            addr_oe_r   <= addr_oe_s;
            fc_oe_r     <= fc_oe_s;
`ifdef FAKE68K_WAIT_TIMEOUT_EN
            wait_cnt_r  <= wait_cnt_s;
`endif
        end
    end

    assign mock_state = state_r;
    assign data_read  = data_read_r;
    assign as_n       = as_n_r;
    assign uds_n      = uds_n_r;
    assign lds_n      = lds_n_r;
    assign w_n        = w_n_r;
    assign fc         = fc_oe_r   ? fc_r    : {3{1'bz}};
    assign logaddr    = addr_oe_r ? addr_r  : {24{1'bz}};
    assign d          = d_oe_r    ? wdata_r : {16{1'bz}};

endmodule

// File: tb/tb_fake_68k.sv
// tb_fake_68k: table-driven per-clock checks of fake_68k bus cycles plus reset and WAIT sequences.
// Honours FAKE68K_WAIT_TIMEOUT_EN to pick the expected WAIT behaviour.

module tb_fake_68k;

    logic        cpuclk;
    logic        cpurst;
    logic [2:0]  cycle_type;
    logic [23:0] mock_addr;
    logic [15:0] mock_data_to_write;
    logic [2:0]  mock_fc;
    logic [15:0] data_read;
    logic [4:0]  mock_state;
    logic        dtack_n;
    logic        berr_n;
    wire  [2:0]  fc;
    logic        w_n;
    wire  [23:0] logaddr;
    wire  [15:0] d;
    logic        as_n;
    logic        uds_n;
    logic        lds_n;
    logic        tb_drv;
    logic [15:0] tb_dval;

    assign d = tb_drv ? tb_dval : {16{1'bz}};

    fake_68k dut (
        .cpuclk(cpuclk), .cpurst(cpurst), .cycle_type(cycle_type), .mock_addr(mock_addr),
        .mock_data_to_write(mock_data_to_write), .mock_fc(mock_fc), .data_read(data_read),
        .mock_state(mock_state), .dtack_n(dtack_n), .berr_n(berr_n), .fc(fc), .w_n(w_n),
        .logaddr(logaddr), .d(d), .as_n(as_n), .uds_n(uds_n), .lds_n(lds_n)
    );

    typedef struct {
        logic [2:0]  ct;
        logic [23:0] addr;
        logic [15:0] wd;
        logic [2:0]  fci;
        logic        dtk;
        logic        ber;
        logic        drv;
        logic [15:0] dval;
        logic [4:0]  st;
        logic        as_n;
        logic        uds_n;
        logic        lds_n;
        logic        w_n;
        logic [15:0] dr;
        logic        cfc;
        logic [2:0]  efc;
        logic        cad;
        logic [23:0] ead;
        logic        cd;
        logic [15:0] ed;
    } vec_t;

    vec_t vecs[$];
    int   checks;
    int   errors;
    int   cur_row;

    initial begin
        cpuclk = 1'b0;
        forever #5 cpuclk = ~cpuclk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    task automatic tick();
        @(posedge cpuclk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s (row %0d): got %h expected %h", nm, cur_row, act, exp);
        end
    endtask

    task automatic row(input logic [2:0] ct, input logic [23:0] addr, input logic [15:0] wd,
                       input logic [2:0] fci, input logic dtk, input logic ber, input logic drv,
                       input logic [15:0] dval, input logic [4:0] st, input logic e_as,
                       input logic e_uds, input logic e_lds, input logic e_w, input logic [15:0] dr,
                       input logic cfc, input logic [2:0] efc, input logic cad,
                       input logic [23:0] ead, input logic cd, input logic [15:0] ed);
        vec_t v;
        v.ct = ct; v.addr = addr; v.wd = wd; v.fci = fci; v.dtk = dtk; v.ber = ber;
        v.drv = drv; v.dval = dval; v.st = st; v.as_n = e_as; v.uds_n = e_uds;
        v.lds_n = e_lds; v.w_n = e_w; v.dr = dr; v.cfc = cfc; v.efc = efc;
        v.cad = cad; v.ead = ead; v.cd = cd; v.ed = ed;
        vecs.push_back(v);
    endtask

    task automatic check_strobes(input logic e_as, input logic e_uds, input logic e_lds, input logic e_w);
        chk("as_n", {31'd0, as_n}, {31'd0, e_as});
        chk("uds_n", {31'd0, uds_n}, {31'd0, e_uds});
        chk("lds_n", {31'd0, lds_n}, {31'd0, e_lds});
        chk("w_n", {31'd0, w_n}, {31'd0, e_w});
    endtask

    task automatic set_in(input logic [2:0] ct, input logic [23:0] addr, input logic [15:0] wd,
                          input logic [2:0] fci, input logic dtk, input logic ber,
                          input logic drv, input logic [15:0] dval);
        cycle_type = ct; mock_addr = addr; mock_data_to_write = wd; mock_fc = fci;
        dtack_n = dtk; berr_n = ber; tb_drv = drv; tb_dval = dval;
    endtask

    initial begin
        int nwait;
        checks = 0;
        errors = 0;
        cur_row = -1;
        cpurst = 1'b1;
        set_in(3'd0, 24'h000000, 16'h0000, 3'd0, 1'b1, 1'b1, 1'b0, 16'h0000);

        // Read word @0, fc 6, dtack low from S2, bus returns 1234
        row(3'd1, 24'h000000, 16'h0000, 3'd6, 1'b1, 1'b1, 1'b1, 16'h1234, 5'd1, 1'b1, 1'b1, 1'b1, 1'b1, 16'h0000, 1'b1, 3'd6, 1'b0, 24'h000000, 1'b0, 16'h0000);
        row(3'd0, 24'h000000, 16'h0000, 3'd6, 1'b1, 1'b1, 1'b1, 16'h1234, 5'd2, 1'b1, 1'b1, 1'b1, 1'b1, 16'h0000, 1'b1, 3'd6, 1'b1, 24'h000000, 1'b0, 16'h0000);
        row(3'd0, 24'h000000, 16'h0000, 3'd6, 1'b0, 1'b1, 1'b1, 16'h1234, 5'd3, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b1, 3'd6, 1'b1, 24'h000000, 1'b1, 16'h1234);
        row(3'd0, 24'h000000, 16'h0000, 3'd6, 1'b0, 1'b1, 1'b1, 16'h1234, 5'd4, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b1, 3'd6, 1'b1, 24'h000000, 1'b1, 16'h1234);
        row(3'd0, 24'h000000, 16'h0000, 3'd6, 1'b0, 1'b1, 1'b1, 16'h1234, 5'd5, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b1, 3'd6, 1'b1, 24'h000000, 1'b1, 16'h1234);
        row(3'd0, 24'h000000, 16'h0000, 3'd6, 1'b0, 1'b1, 1'b1, 16'h1234, 5'd6, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b1, 3'd6, 1'b1, 24'h000000, 1'b1, 16'h1234);
        row(3'd0, 24'h000000, 16'h0000, 3'd6, 1'b0, 1'b1, 1'b1, 16'h1234, 5'd7, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b1, 3'd6, 1'b1, 24'h000000, 1'b1, 16'h1234);
        row(3'd0, 24'h000000, 16'h0000, 3'd6, 1'b0, 1'b1, 1'b1, 16'h1234, 5'd8, 1'b1, 1'b1, 1'b1, 1'b1, 16'h1234, 1'b1, 3'd6, 1'b1, 24'h000000, 1'b0, 16'h0000);
        row(3'd0, 24'h000000, 16'h0000, 3'd6, 1'b1, 1'b1, 1'b0, 16'h0000, 5'd0, 1'b1, 1'b1, 1'b1, 1'b1, 16'h1234, 1'b0, 3'd0, 1'b0, 24'h000000, 1'b0, 16'h0000);
        // Write lower byte @5 data BEEF; mock inputs scrambled after S0 must be ignored
        row(3'd6, 24'h000005, 16'hBEEF, 3'd5, 1'b1, 1'b1, 1'b0, 16'h0000, 5'd1, 1'b1, 1'b1, 1'b1, 1'b1, 16'h1234, 1'b1, 3'd5, 1'b0, 24'h000000, 1'b0, 16'h0000);
        row(3'd0, 24'hFFFFFF, 16'h0000, 3'd0, 1'b1, 1'b1, 1'b0, 16'h0000, 5'd2, 1'b1, 1'b1, 1'b1, 1'b1, 16'h1234, 1'b1, 3'd5, 1'b1, 24'h000004, 1'b0, 16'h0000);
        row(3'd0, 24'hFFFFFF, 16'h0000, 3'd0, 1'b0, 1'b1, 1'b0, 16'h0000, 5'd3, 1'b0, 1'b1, 1'b1, 1'b0, 16'h1234, 1'b1, 3'd5, 1'b1, 24'h000004, 1'b0, 16'h0000);
        row(3'd0, 24'hFFFFFF, 16'h0000, 3'd0, 1'b0, 1'b1, 1'b0, 16'h0000, 5'd4, 1'b0, 1'b1, 1'b1, 1'b0, 16'h1234, 1'b1, 3'd5, 1'b1, 24'h000004, 1'b1, 16'hBEEF);
        row(3'd0, 24'hFFFFFF, 16'h0000, 3'd0, 1'b0, 1'b1, 1'b0, 16'h0000, 5'd5, 1'b0, 1'b1, 1'b0, 1'b0, 16'h1234, 1'b1, 3'd5, 1'b1, 24'h000004, 1'b1, 16'hBEEF);
        row(3'd0, 24'hFFFFFF, 16'h0000, 3'd0, 1'b0, 1'b1, 1'b0, 16'h0000, 5'd6, 1'b0, 1'b1, 1'b0, 1'b0, 16'h1234, 1'b1, 3'd5, 1'b1, 24'h000004, 1'b1, 16'hBEEF);
        row(3'd0, 24'hFFFFFF, 16'h0000, 3'd0, 1'b0, 1'b1, 1'b0, 16'h0000, 5'd7, 1'b0, 1'b1, 1'b0, 1'b0, 16'h1234, 1'b1, 3'd5, 1'b1, 24'h000004, 1'b1, 16'hBEEF);
        row(3'd0, 24'hFFFFFF, 16'h0000, 3'd0, 1'b0, 1'b1, 1'b1, 16'hA5A5, 5'd8, 1'b1, 1'b1, 1'b1, 1'b0, 16'h1234, 1'b1, 3'd5, 1'b1, 24'h000004, 1'b1, 16'hA5A5);
        row(3'd0, 24'h000000, 16'h0000, 3'd0, 1'b1, 1'b1, 1'b0, 16'h0000, 5'd0, 1'b1, 1'b1, 1'b1, 1'b1, 16'h1234, 1'b0, 3'd0, 1'b0, 24'h000000, 1'b0, 16'h0000);
        // Read upper byte @123457, dtack delayed: three WAIT clocks
        row(3'd3, 24'h123457, 16'h0000, 3'd1, 1'b1, 1'b1, 1'b1, 16'hCAFE, 5'd1, 1'b1, 1'b1, 1'b1, 1'b1, 16'h1234, 1'b1, 3'd1, 1'b0, 24'h000000, 1'b0, 16'h0000);
        row(3'd0, 24'h123457, 16'h0000, 3'd1, 1'b1, 1'b1, 1'b1, 16'hCAFE, 5'd2, 1'b1, 1'b1, 1'b1, 1'b1, 16'h1234, 1'b1, 3'd1, 1'b1, 24'h123456, 1'b0, 16'h0000);
        row(3'd0, 24'h123457, 16'h0000, 3'd1, 1'b1, 1'b1, 1'b1, 16'hCAFE, 5'd3, 1'b0, 1'b0, 1'b1, 1'b1, 16'h1234, 1'b1, 3'd1, 1'b1, 24'h123456, 1'b0, 16'h0000);
        row(3'd0, 24'h123457, 16'h0000, 3'd1, 1'b1, 1'b1, 1'b1, 16'hCAFE, 5'd4, 1'b0, 1'b0, 1'b1, 1'b1, 16'h1234, 1'b1, 3'd1, 1'b1, 24'h123456, 1'b0, 16'h0000);
        row(3'd0, 24'h123457, 16'h0000, 3'd1, 1'b1, 1'b1, 1'b1, 16'hCAFE, 5'd5, 1'b0, 1'b0, 1'b1, 1'b1, 16'h1234, 1'b1, 3'd1, 1'b1, 24'h123456, 1'b0, 16'h0000);
        row(3'd0, 24'h123457, 16'h0000, 3'd1, 1'b1, 1'b1, 1'b1, 16'hCAFE, 5'd9, 1'b0, 1'b0, 1'b1, 1'b1, 16'h1234, 1'b1, 3'd1, 1'b1, 24'h123456, 1'b0, 16'h0000);
        row(3'd0, 24'h123457, 16'h0000, 3'd1, 1'b1, 1'b1, 1'b1, 16'hCAFE, 5'd9, 1'b0, 1'b0, 1'b1, 1'b1, 16'h1234, 1'b1, 3'd1, 1'b1, 24'h123456, 1'b0, 16'h0000);
        row(3'd0, 24'h123457, 16'h0000, 3'd1, 1'b1, 1'b1, 1'b1, 16'hCAFE, 5'd9, 1'b0, 1'b0, 1'b1, 1'b1, 16'h1234, 1'b1, 3'd1, 1'b1, 24'h123456, 1'b0, 16'h0000);
        row(3'd0, 24'h123457, 16'h0000, 3'd1, 1'b0, 1'b1, 1'b1, 16'hCAFE, 5'd6, 1'b0, 1'b0, 1'b1, 1'b1, 16'h1234, 1'b1, 3'd1, 1'b1, 24'h123456, 1'b0, 16'h0000);
        row(3'd0, 24'h123457, 16'h0000, 3'd1, 1'b0, 1'b1, 1'b1, 16'hCAFE, 5'd7, 1'b0, 1'b0, 1'b1, 1'b1, 16'h1234, 1'b1, 3'd1, 1'b1, 24'h123456, 1'b0, 16'h0000);
        row(3'd0, 24'h123457, 16'h0000, 3'd1, 1'b0, 1'b1, 1'b1, 16'hCAFE, 5'd8, 1'b1, 1'b1, 1'b1, 1'b1, 16'hCAFE, 1'b1, 3'd1, 1'b1, 24'h123456, 1'b0, 16'h0000);
        row(3'd0, 24'h123457, 16'h0000, 3'd1, 1'b1, 1'b1, 1'b1, 16'hCAFE, 5'd0, 1'b1, 1'b1, 1'b1, 1'b1, 16'hCAFE, 1'b0, 3'd0, 1'b0, 24'h000000, 1'b0, 16'h0000);
        // Read word @100 with berr_n and dtack_n both low in S4
        row(3'd1, 24'h000100, 16'h0000, 3'd2, 1'b1, 1'b1, 1'b1, 16'h9999, 5'd1, 1'b1, 1'b1, 1'b1, 1'b1, 16'hCAFE, 1'b1, 3'd2, 1'b0, 24'h000000, 1'b0, 16'h0000);
        row(3'd0, 24'h000100, 16'h0000, 3'd2, 1'b1, 1'b1, 1'b1, 16'h9999, 5'd2, 1'b1, 1'b1, 1'b1, 1'b1, 16'hCAFE, 1'b1, 3'd2, 1'b1, 24'h000100, 1'b0, 16'h0000);
        row(3'd0, 24'h000100, 16'h0000, 3'd2, 1'b1, 1'b1, 1'b1, 16'h9999, 5'd3, 1'b0, 1'b0, 1'b0, 1'b1, 16'hCAFE, 1'b1, 3'd2, 1'b1, 24'h000100, 1'b0, 16'h0000);
        row(3'd0, 24'h000100, 16'h0000, 3'd2, 1'b1, 1'b1, 1'b1, 16'h9999, 5'd4, 1'b0, 1'b0, 1'b0, 1'b1, 16'hCAFE, 1'b1, 3'd2, 1'b1, 24'h000100, 1'b0, 16'h0000);
        row(3'd0, 24'h000100, 16'h0000, 3'd2, 1'b1, 1'b1, 1'b1, 16'h9999, 5'd5, 1'b0, 1'b0, 1'b0, 1'b1, 16'hCAFE, 1'b1, 3'd2, 1'b1, 24'h000100, 1'b0, 16'h0000);
        row(3'd0, 24'h000100, 16'h0000, 3'd2, 1'b0, 1'b0, 1'b1, 16'h9999, 5'd10, 1'b1, 1'b1, 1'b1, 1'b1, 16'hCAFE, 1'b1, 3'd2, 1'b1, 24'h000100, 1'b0, 16'h0000);
        row(3'd0, 24'h000100, 16'h0000, 3'd2, 1'b1, 1'b1, 1'b1, 16'h9999, 5'd0, 1'b1, 1'b1, 1'b1, 1'b1, 16'hCAFE, 1'b0, 3'd0, 1'b0, 24'h000000, 1'b0, 16'h0000);
        // Back-to-back lower byte reads @2: cycle_type held, one IDLE clock between cycles
        row(3'd4, 24'h000002, 16'h0000, 3'd5, 1'b0, 1'b1, 1'b1, 16'h0F0F, 5'd1, 1'b1, 1'b1, 1'b1, 1'b1, 16'hCAFE, 1'b1, 3'd5, 1'b0, 24'h000000, 1'b0, 16'h0000);
        row(3'd4, 24'h000002, 16'h0000, 3'd5, 1'b0, 1'b1, 1'b1, 16'h0F0F, 5'd2, 1'b1, 1'b1, 1'b1, 1'b1, 16'hCAFE, 1'b1, 3'd5, 1'b1, 24'h000002, 1'b0, 16'h0000);
        row(3'd4, 24'h000002, 16'h0000, 3'd5, 1'b0, 1'b1, 1'b1, 16'h0F0F, 5'd3, 1'b0, 1'b1, 1'b0, 1'b1, 16'hCAFE, 1'b1, 3'd5, 1'b1, 24'h000002, 1'b0, 16'h0000);
        row(3'd4, 24'h000002, 16'h0000, 3'd5, 1'b0, 1'b1, 1'b1, 16'h0F0F, 5'd4, 1'b0, 1'b1, 1'b0, 1'b1, 16'hCAFE, 1'b1, 3'd5, 1'b1, 24'h000002, 1'b0, 16'h0000);
        row(3'd4, 24'h000002, 16'h0000, 3'd5, 1'b0, 1'b1, 1'b1, 16'h0F0F, 5'd5, 1'b0, 1'b1, 1'b0, 1'b1, 16'hCAFE, 1'b1, 3'd5, 1'b1, 24'h000002, 1'b0, 16'h0000);
        row(3'd4, 24'h000002, 16'h0000, 3'd5, 1'b0, 1'b1, 1'b1, 16'h0F0F, 5'd6, 1'b0, 1'b1, 1'b0, 1'b1, 16'hCAFE, 1'b1, 3'd5, 1'b1, 24'h000002, 1'b0, 16'h0000);
        row(3'd4, 24'h000002, 16'h0000, 3'd5, 1'b0, 1'b1, 1'b1, 16'h0F0F, 5'd7, 1'b0, 1'b1, 1'b0, 1'b1, 16'hCAFE, 1'b1, 3'd5, 1'b1, 24'h000002, 1'b0, 16'h0000);
        row(3'd4, 24'h000002, 16'h0000, 3'd5, 1'b0, 1'b1, 1'b1, 16'h0F0F, 5'd8, 1'b1, 1'b1, 1'b1, 1'b1, 16'h0F0F, 1'b1, 3'd5, 1'b1, 24'h000002, 1'b0, 16'h0000);
        row(3'd4, 24'h000002, 16'h0000, 3'd5, 1'b0, 1'b1, 1'b1, 16'h0F0F, 5'd0, 1'b1, 1'b1, 1'b1, 1'b1, 16'h0F0F, 1'b0, 3'd0, 1'b0, 24'h000000, 1'b0, 16'h0000);
        row(3'd4, 24'h000002, 16'h0000, 3'd5, 1'b0, 1'b1, 1'b1, 16'hF0F0, 5'd1, 1'b1, 1'b1, 1'b1, 1'b1, 16'h0F0F, 1'b1, 3'd5, 1'b0, 24'h000000, 1'b0, 16'h0000);
        row(3'd0, 24'h000002, 16'h0000, 3'd5, 1'b0, 1'b1, 1'b1, 16'hF0F0, 5'd2, 1'b1, 1'b1, 1'b1, 1'b1, 16'h0F0F, 1'b1, 3'd5, 1'b1, 24'h000002, 1'b0, 16'h0000);
        row(3'd0, 24'h000002, 16'h0000, 3'd5, 1'b0, 1'b1, 1'b1, 16'hF0F0, 5'd3, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0F0F, 1'b1, 3'd5, 1'b1, 24'h000002, 1'b0, 16'h0000);
        row(3'd0, 24'h000002, 16'h0000, 3'd5, 1'b0, 1'b1, 1'b1, 16'hF0F0, 5'd4, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0F0F, 1'b1, 3'd5, 1'b1, 24'h000002, 1'b0, 16'h0000);
        row(3'd0, 24'h000002, 16'h0000, 3'd5, 1'b0, 1'b1, 1'b1, 16'hF0F0, 5'd5, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0F0F, 1'b1, 3'd5, 1'b1, 24'h000002, 1'b0, 16'h0000);
        row(3'd0, 24'h000002, 16'h0000, 3'd5, 1'b0, 1'b1, 1'b1, 16'hF0F0, 5'd6, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0F0F, 1'b1, 3'd5, 1'b1, 24'h000002, 1'b0, 16'h0000);
        row(3'd0, 24'h000002, 16'h0000, 3'd5, 1'b0, 1'b1, 1'b1, 16'hF0F0, 5'd7, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0F0F, 1'b1, 3'd5, 1'b1, 24'h000002, 1'b0, 16'h0000);
        row(3'd0, 24'h000002, 16'h0000, 3'd5, 1'b0, 1'b1, 1'b1, 16'hF0F0, 5'd8, 1'b1, 1'b1, 1'b1, 1'b1, 16'hF0F0, 1'b1, 3'd5, 1'b1, 24'h000002, 1'b0, 16'h0000);
        row(3'd0, 24'h000002, 16'h0000, 3'd5, 1'b1, 1'b1, 1'b0, 16'h0000, 5'd0, 1'b1, 1'b1, 1'b1, 1'b1, 16'hF0F0, 1'b0, 3'd0, 1'b0, 24'h000000, 1'b0, 16'h0000);

        // Reset state
        tick();
        tick();
        chk("reset_state", {27'd0, mock_state}, 32'd0);
        check_strobes(1'b1, 1'b1, 1'b1, 1'b1);
        chk("reset_data_read", {16'd0, data_read}, 32'd0);
        cpurst = 1'b0;
        tick();
        chk("idle_state", {27'd0, mock_state}, 32'd0);

        foreach (vecs[i]) begin
            cur_row = i;
            set_in(vecs[i].ct, vecs[i].addr, vecs[i].wd, vecs[i].fci, vecs[i].dtk, vecs[i].ber, vecs[i].drv, vecs[i].dval);
            tick();
            chk("state", {27'd0, mock_state}, {27'd0, vecs[i].st});
            check_strobes(vecs[i].as_n, vecs[i].uds_n, vecs[i].lds_n, vecs[i].w_n);
            chk("data_read", {16'd0, data_read}, {16'd0, vecs[i].dr});
            if (vecs[i].cfc) chk("fc", {29'd0, fc}, {29'd0, vecs[i].efc});
            if (vecs[i].cad) chk("logaddr", {8'd0, logaddr}, {8'd0, vecs[i].ead});
            if (vecs[i].cd) chk("d", {16'd0, d}, {16'd0, vecs[i].ed});
        end

        // Reset asserted in S3 of a write word
        cur_row = 1000;
        set_in(3'd2, 24'h000010, 16'h7777, 3'd5, 1'b0, 1'b1, 1'b0, 16'h0000);
        tick();
        cycle_type = 3'd0;
        tick();
        tick();
        tick();
        chk("rst_pre_state", {27'd0, mock_state}, 32'd4);
        chk("rst_pre_d", {16'd0, d}, 32'h0000_7777);
        cpurst = 1'b1;
        tb_drv = 1'b1;
        tb_dval = 16'hA5A5;
        tick();
        chk("rst_mid_state", {27'd0, mock_state}, 32'd0);
        check_strobes(1'b1, 1'b1, 1'b1, 1'b1);
        chk("rst_mid_data_read", {16'd0, data_read}, 32'd0);
        chk("rst_mid_d_released", {16'd0, d}, 32'h0000_A5A5);
        cpurst = 1'b0;
        tb_drv = 1'b0;
        tick();
        chk("rst_after_idle", {27'd0, mock_state}, 32'd0);

        // dtack_n and berr_n never asserted
        cur_row = 2000;
        set_in(3'd1, 24'h000200, 16'h0000, 3'd6, 1'b1, 1'b1, 1'b1, 16'h4321);
        tick();
        cycle_type = 3'd0;
        tick();
        tick();
        tick();
        tick();
        chk("to_s4", {27'd0, mock_state}, 32'd5);
        nwait = 0;
`ifdef FAKE68K_WAIT_TIMEOUT_EN
        for (int i = 0; i < 40; i++) begin
            tick();
            if (mock_state == 5'd9) nwait++;
            else break;
        end
        chk("to_wait_count", nwait, 32'd32);
        chk("to_berr", {27'd0, mock_state}, 32'd10);
        check_strobes(1'b1, 1'b1, 1'b1, 1'b1);
        tick();
        chk("to_idle", {27'd0, mock_state}, 32'd0);
        chk("to_data_read", {16'd0, data_read}, 32'd0);
`else
        for (int i = 0; i < 100; i++) begin
            tick();
            if (mock_state == 5'd9) nwait++;
        end
        chk("wait_count", nwait, 32'd100);
        chk("still_wait", {27'd0, mock_state}, 32'd9);
        dtack_n = 1'b0;
        tick();
        chk("wait_release", {27'd0, mock_state}, 32'd6);
        tick();
        tick();
        chk("wait_s7", {27'd0, mock_state}, 32'd8);
        chk("wait_data_read", {16'd0, data_read}, 32'h0000_4321);
        tick();
        chk("wait_idle", {27'd0, mock_state}, 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fake_68k.md
# fake_68k

Bus-functional model of a MC68000 CPU bus interface, used in system-level benches to drive the glue logic (`prototype`) with real 68000-style read and write cycles. Each cycle is requested from the bench through mock inputs. The block sequences address, function code, strobe and data signals through the S0–S7 bus states, honouring `dtack_n` and `berr_n`. It returns read data and exposes its current state for checking.

## Interface
Parameters: none.

Clock and reset: one clock; reset is synchronous and active-high. Ports are named `cpuclk` (clock) and `cpurst` (reset).

- `cpuclk` in 1: CPU clock; all state changes on rising edge.
- `cpurst` in 1: synchronous active-high reset.
- `cycle_type` in 3: 0 idle, 1 read word, 2 write word, 3 read upper byte, 4 read lower byte, 5 write upper byte, 6 write lower byte, 7 idle.
- `mock_addr` in 24: byte address of the cycle; bit 0 is ignored.
- `mock_data_to_write` in 16: write data.
- `mock_fc` in 3: function code for the cycle.
- `data_read` out 16: last successfully read bus word.
- `mock_state` out 5: current bus state, encoded as below.
- `dtack_n` in 1: data transfer acknowledge, active low.
- `berr_n` in 1: bus error, active low.
- `fc` out 3: function code to the bus.
- `w_n` out 1: write strobe. Low means write (68000 R/W̄).
- `logaddr` out 24: address bus.
- `d` inout 16: data bus.
- `as_n`, `uds_n`, `lds_n` out 1 each: address strobe and upper/lower data strobes.

## Operation
- `mock_state` encoding: 0 IDLE; 1–8 = S0–S7; 9 WAIT (repeated S4); 10 BERR.
- IDLE:
  - Strobes and `w_n` = 1.
  - `d`, `logaddr` and `fc` are high-Z.
  - When `cycle_type` is 1–6 (not X/Z) at a clock edge, latch all mock inputs and go to S0.
- S0: drive `fc` = latched fc.
- S1: drive `logaddr` = {addr[23:1], 1'b0}.
- S2:
  - `as_n` = 0.
  - For reads, assert the selected data strobes: word = both, upper = `uds_n`, lower = `lds_n`.
  - For writes, `w_n` = 0.
- S3: for writes, drive `d` = latched write data.
- S4 and WAIT: for writes, assert the selected data strobes. Sample the bus each clock:
  - `berr_n` = 0 → BERR. Bus error wins over `dtack_n`.
  - Otherwise `dtack_n` = 0 → S5.
  - Otherwise → WAIT.
- S5, S6: hold. At the end of S6, reads latch `d` into `data_read` (full 16 bits, including for byte reads).
- S7: negate `as_n`, `uds_n` and `lds_n`; release `d`; next state IDLE.
- BERR:
  - Negate all strobes, release `d`, leave `data_read` unchanged.
  - Next state IDLE.
- Within a cycle, `w_n` stays low from S2 through S7 for writes.
- `logaddr` and `fc` are held from S1/S0 through S7/BERR.
- Back-to-back cycles: if `cycle_type` is still valid in IDLE, a new cycle starts with the next S0. At least one IDLE clock always separates cycles.
- Changes to the mock inputs during a cycle have no effect; they are latched at IDLE→S0.

## Timing
- One bus state per `cpuclk` cycle. A zero-wait cycle takes 8 clocks, S0–S7.
- `data_read` updates 7 clocks after the S0 edge on a zero-wait read. Each WAIT clock adds one clock.
- Reset, including mid-cycle:
  - Next state IDLE; `data_read` = 0.
  - Strobes and `w_n` = 1; `d`, `logaddr` and `fc` high-Z.
  - Any cycle in progress is aborted with no data update.

## Configuration
- `FAKE68K_WAIT_TIMEOUT_EN`:
  - Defined: a 5-bit counter of WAIT clocks. A 32nd consecutive WAIT with `dtack_n` and `berr_n` both high goes to BERR.
  - Undefined: WAIT persists until `dtack_n` or `berr_n` asserts.

## Test plan
- Read word at 0x000000 with fc=110 and `dtack_n` low from S2, bus returning 0x1234:
  - `as_n` low in S2–S6.
  - `uds_n`/`lds_n` low in S2–S6.
  - `w_n` = 1 throughout.
  - `data_read` = 0x1234 after S6.
  - IDLE after 8 clocks.
- Write lower byte at 0x000005 with data 0xBEEF:
  - `logaddr` = 0x000004.
  - `w_n` low in S2–S7.
  - `d` = 0xBEEF from S3.
  - `lds_n` low in S4–S6; `uds_n` stays high.
- Read with `dtack_n` delayed 3 clocks:
  - `mock_state` = 9 for 3 clocks.
  - Completion delayed by 3 clocks with correct data.
- `berr_n` and `dtack_n` both low in S4:
  - State 10, then IDLE.
  - `data_read` unchanged.
  - Strobes negated.
- `cpurst` asserted in S3 of a write:
  - Next clock: IDLE, `d` high-Z, all strobes = 1, `data_read` = 0.
- With `FAKE68K_WAIT_TIMEOUT_EN` defined and `dtack_n` never asserted:
  - BERR after 32 WAIT clocks.
- With `FAKE68K_WAIT_TIMEOUT_EN` undefined:
  - Still in WAIT after 100 clocks.
